// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer.
// The block accepts two WIDTH-bit operands and a carry-in on a valid/ready
// handshake. It drives one full_adder cell LSB-first, one bit per clock,
// with the carry kept in a register between bits. The assembled {cout, sum}
// is held on an output valid/ready handshake until the consumer takes it.

// Single-bit full adder cell used by the sequencer.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] a_sh, a_sh_d;
   logic [WIDTH-1:0] b_sh, b_sh_d;
   logic [WIDTH-1:0] s_sh, s_sh_d;
   logic [WIDTH-1:0] sum_d;
   logic             carry_q, carry_d;
   logic             cout_d;
   logic             in_ready_d;
   logic             out_valid_d;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
   logic             fa_sum, fa_cout;
   logic             last_bit;

   // The adder always sees the current LSBs and the carry from the previous bit.
   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
   assign busy     = (state != IDLE);

   // Next-state and datapath decode: accept, serial add, then hold the result.
   always_comb begin
      // NOTE: every variable gets a default before the case statement.
      // Without the default, a path that does not assign it would infer a latch.
      state_d     = state;
      a_sh_d      = a_sh;
      b_sh_d      = b_sh;
      s_sh_d      = s_sh;
      carry_d     = carry_q;
      bit_cnt_d   = bit_cnt;
      sum_d       = sum;
      cout_d      = cout;
      in_ready_d  = in_ready;
      out_valid_d = out_valid;

      case (state)
         IDLE: begin
            // in_ready comes up on the first edge spent in IDLE, including after reset.
            in_ready_d = 1'b1;
            if (in_valid && in_ready) begin
               a_sh_d     = op_a;
               b_sh_d     = op_b;
               carry_d    = cin;
               bit_cnt_d  = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end

         RUN: begin
            a_sh_d    = a_sh >> 1;
            b_sh_d    = b_sh >> 1;
            s_sh_d    = {fa_sum, s_sh[WIDTH-1:1]};
            carry_d   = fa_cout;
            bit_cnt_d = bit_cnt + CNT_W'(1);
            if (last_bit) begin
               // s_sh_d now holds all WIDTH sum bits, so it is loaded directly.
               sum_d       = s_sh_d;
               cout_d      = fa_cout;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end

         DONE: begin
            // The result is returned to IDLE first, so no operand is accepted on this edge.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         s_sh      <= '0;
         carry_q   <= 1'b0;
         bit_cnt   <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here. All registers then update
         // together from the values they had before the edge.
         state     <= state_d;
         a_sh      <= a_sh_d;
         b_sh      <= b_sh_d;
         s_sh      <= s_sh_d;
         carry_q   <= carry_d;
         bit_cnt   <= bit_cnt_d;
         sum       <= sum_d;
         cout      <= cout_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer.
// A WIDTH=8 instance gets the directed scenarios. WIDTH=8 and WIDTH=16
// instances then run back-to-back random traffic. Expected results come from
// plain integer addition.

module tb_serial_add_sequencer;

   logic clk;
   logic rst_n;

   logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
   logic [7:0]  op_a8, op_b8, sum8;

   logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, busy16;
   logic [15:0] op_a16, op_b16, sum16;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   serial_add_sequencer #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .op_a      (op_a8),
      .op_b      (op_b8),
      .cin       (cin8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .cout      (cout8),
      .busy      (busy8)
   );

   serial_add_sequencer #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .op_a      (op_a16),
      .op_b      (op_b16),
      .cin       (cin16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .sum       (sum16),
      .cout      (cout16),
      .busy      (busy16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Advance one clock edge and step just past it, so outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the full (WIDTH+1)-bit sum, given as {cout, sum}.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
      return a + b + 32'(c);
   endfunction

   // Present operands to dut8 and return just after the accept edge.
   task automatic send8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
      int n;
      op_a8 = a; op_b8 = b; cin8 = c; in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 50) begin tick(); n++; end
      check({tag, "_ready_timeout"}, 32'(n < 50), 32'd1);
      tick();
      in_valid8 = 1'b0;
      check({tag, "_busy_run"}, 32'(busy8), 32'd1);
      check({tag, "_in_ready_run"}, 32'(in_ready8), 32'd0);
   endtask

   // Wait for out_valid on dut8 and check that it came exactly 8 edges after accept.
   task automatic wait8(input string tag);
      int lat;
      lat = 0;
      while (!out_valid8 && lat < 100) begin tick(); lat++; end
      check({tag, "_latency"}, 32'(lat), 32'd8);
   endtask

   task automatic expect8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
      check({tag, "_result"}, {23'd0, cout8, sum8}, ref_add(32'(a), 32'(b), c) & 32'h1FF);
   endtask

   // Back-to-back random traffic on dut8: in_valid and out_ready held high.
   task automatic b2b8();
      logic [7:0] a, b;
      logic       c;
      int n, lat, acc, prev;
      prev = 0;
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
         op_a8 = a; op_b8 = b; cin8 = c;
         n = 0;
         while (!in_ready8 && n < 50) begin tick(); n++; end
         check("b2b8_ready_timeout", 32'(n < 50), 32'd1);
         tick();
         acc = cyc;
         if (i > 0) check("b2b8_spacing", 32'(acc - prev), 32'd10);
         prev = acc;
         op_a8 = 8'($urandom); op_b8 = 8'($urandom); cin8 = 1'($urandom);
         lat = 0;
         while (!out_valid8 && lat < 100) begin tick(); lat++; end
         check("b2b8_result", {23'd0, cout8, sum8}, ref_add(32'(a), 32'(b), c) & 32'h1FF);
      end
      in_valid8 = 1'b0;
   endtask

   // Back-to-back random traffic on dut16.
   task automatic b2b16();
      logic [15:0] a, b;
      logic        c;
      int n, lat, acc, prev;
      prev = 0;
      in_valid16 = 1'b1; out_ready16 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         op_a16 = a; op_b16 = b; cin16 = c;
         n = 0;
         while (!in_ready16 && n < 50) begin tick(); n++; end
         check("b2b16_ready_timeout", 32'(n < 50), 32'd1);
         tick();
         acc = cyc;
         if (i > 0) check("b2b16_spacing", 32'(acc - prev), 32'd18);
         prev = acc;
         op_a16 = 16'($urandom); op_b16 = 16'($urandom); cin16 = 1'($urandom);
         lat = 0;
         while (!out_valid16 && lat < 100) begin tick(); lat++; end
         check("b2b16_result", {15'd0, cout16, sum16}, ref_add(32'(a), 32'(b), c) & 32'h1FFFF);
      end
      in_valid16 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      in_valid8 = 1'b0;  op_a8 = '0;  op_b8 = '0;  cin8 = 1'b0;  out_ready8 = 1'b1;
      in_valid16 = 1'b0; op_a16 = '0; op_b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
      #1 rst_n = 1'b0;
      #2;

      // Reset state.
      check("rst_in_ready", 32'(in_ready8), 32'd0);
      check("rst_out_valid", 32'(out_valid8), 32'd0);
      check("rst_sum", 32'(sum8), 32'd0);
      check("rst_cout", 32'(cout8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      tick();
      tick();
      check("rst_in_ready_held", 32'(in_ready8), 32'd0);
      rst_n = 1'b1;
      check("rel_in_ready_before_edge", 32'(in_ready8), 32'd0);
      tick();
      check("rel_in_ready_after_edge", 32'(in_ready8), 32'd1);

      // 1: basic add, single-cycle out_valid with out_ready high.
      send8("t1", 8'h35, 8'h4A, 1'b0);
      wait8("t1");
      check("t1_sum", 32'(sum8), 32'h7F);
      check("t1_cout", 32'(cout8), 32'd0);
      expect8("t1", 8'h35, 8'h4A, 1'b0);
      tick();
      check("t1_out_valid_drop", 32'(out_valid8), 32'd0);
      check("t1_in_ready_back", 32'(in_ready8), 32'd1);
      check("t1_busy_idle", 32'(busy8), 32'd0);
      check("t1_sum_hold", 32'(sum8), 32'h7F);

      // 2: carry out and full wrap-around.
      send8("t2a", 8'hFF, 8'h01, 1'b0);
      wait8("t2a");
      check("t2a_sum", 32'(sum8), 32'h00);
      check("t2a_cout", 32'(cout8), 32'd1);
      tick();
      send8("t2b", 8'hFF, 8'hFF, 1'b1);
      wait8("t2b");
      check("t2b_sum", 32'(sum8), 32'hFF);
      check("t2b_cout", 32'(cout8), 32'd1);
      tick();

      // 3: backpressure while the result is held; in_valid pulses are ignored.
      out_ready8 = 1'b0;
      send8("t3", 8'h9C, 8'h81, 1'b1);
      wait8("t3");
      for (int i = 0; i < 5; i++) begin
         in_valid8 = i[0];
         op_a8 = 8'($urandom); op_b8 = 8'($urandom);
         tick();
         check("t3_out_valid_hold", 32'(out_valid8), 32'd1);
         check("t3_in_ready_low", 32'(in_ready8), 32'd0);
         expect8("t3_hold", 8'h9C, 8'h81, 1'b1);
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      tick();
      check("t3_out_valid_drop", 32'(out_valid8), 32'd0);
      check("t3_in_ready_back", 32'(in_ready8), 32'd1);

      // 4: operands changed during RUN do not affect the result.
      send8("t4", 8'h10, 8'h20, 1'b0);
      op_a8 = 8'hAA; op_b8 = 8'h55; cin8 = 1'b1;
      wait8("t4");
      check("t4_sum", 32'(sum8), 32'h30);
      check("t4_cout", 32'(cout8), 32'd0);
      tick();

      // 5: reset mid-RUN, after three bits have been processed.
      send8("t5", 8'h5A, 8'h3C, 1'b1);
      tick(); tick(); tick();
      check("t5_out_valid_midrun", 32'(out_valid8), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", 32'(out_valid8), 32'd0);
      check("t5_rst_sum", 32'(sum8), 32'd0);
      check("t5_rst_cout", 32'(cout8), 32'd0);
      check("t5_rst_busy", 32'(busy8), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready8), 32'd0);
      tick();
      check("t5_rst_in_ready_held", 32'(in_ready8), 32'd0);
      rst_n = 1'b1;
      tick();
      check("t5_rel_in_ready", 32'(in_ready8), 32'd1);
      send8("t5b", 8'h01, 8'h02, 1'b0);
      wait8("t5b");
      check("t5b_sum", 32'(sum8), 32'h03);
      check("t5b_cout", 32'(cout8), 32'd0);
      tick();

      // 6: back-to-back random traffic on both widths in parallel.
      fork
         b2b8();
         b2b16();
      join

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Bit-serial adder sequencer. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then drives one instantiated full_adder LSB-first, one bit per clock, with a registered carry loop. It assembles the sum bits and presents sum/cout on an output valid/ready handshake. It sits directly around the full_adder cell, feeding its A/B/Cin and consuming its Sum/Cout.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (op_a + op_b + cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. in_ready=0, out_valid=0, sum=0, cout=0, busy=0. Internal shift registers, carry register and bit counter are cleared.
- in_ready is a register. It rises on the first clk edge after rst_n deasserts. It is never high while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid & in_ready: capture op_a, op_b and cin into the a_sh, b_sh and carry_q registers, clear bit_cnt, clear in_ready, and go to RUN.
  - This edge is the accept edge (edge 0).
- RUN:
  - full_adder inputs: A=a_sh[0], B=b_sh[0], Cin=carry_q.
  - On each edge:
    - shift a_sh and b_sh right by one;
    - shift Sum into the MSB of s_sh (shift right);
    - carry_q <= Cout;
    - bit_cnt++.
  - The edge that processes bit WIDTH-1 (edge WIDTH after accept) also does the following:
    - loads sum <= final s_sh and cout <= Cout;
    - sets out_valid;
    - goes to DONE.
  - Latency: out_valid is high exactly WIDTH clocks after the accept edge.
- DONE:
  - out_valid=1. sum and cout are held stable. in_ready=0.
  - On an edge with out_ready=1: clear out_valid, set in_ready, go to IDLE.
  - No new operand is accepted on that same edge.
- Throughput: with in_valid and out_ready held high, one result every WIDTH+2 clocks.
- sum and cout change only on the RUN->DONE edge and on reset. After the handshake they hold the last result. They are never updated mid-RUN.
- Inputs:
  - op_a, op_b and cin are sampled only on the accept edge. Changes afterwards are ignored.
  - in_valid while in_ready=0 is ignored. No buffering, no error flag.
- Arithmetic: result equals the full (WIDTH+1)-bit value op_a + op_b + cin, split as {cout, sum}. Wrap-around is expected, not an error.
- bit_cnt width is clog2(WIDTH+1). The counter never exceeds WIDTH-1 in RUN.
- Reset mid-operation: any state is aborted immediately and the partial result is discarded. Outputs take their reset values. Restart follows the in_ready rule above.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. WIDTH=8, op_a=0x35, op_b=0x4A, cin=0, out_ready=1 -> sum=0x7F, cout=0; out_valid rises exactly 8 clocks after the accept edge and stays high for 1 clock.
2. op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. Backpressure: out_ready=0 for 5 clocks after out_valid -> out_valid, sum and cout held, in_ready=0, and in_valid pulses ignored. Then out_ready=1 -> out_valid=0 and in_ready=1 after the next edge.
4. Operand change after accept: op_a=0x10, op_b=0x20 accepted, then op_a driven to 0xAA during RUN -> sum=0x30.
5. rst_n low mid-RUN (after 3 bits) -> out_valid=0, sum=0x00, cout=0, busy=0, in_ready=0 while in reset; in_ready=1 one edge after release; a following op of 0x01+0x02 gives sum=0x03.
6. Back-to-back: in_valid=1 and out_ready=1 constantly, 200 random operand/cin triples, WIDTH=8 and WIDTH=16 -> every result matches op_a+op_b+cin; accept edges are spaced exactly WIDTH+2 clocks apart.
